// File: rtl/fetch_queue.sv
// Instruction fetch queue: AXI4 single-beat reads with epoch-tagged squashing, branch prediction redirect.
// Optional FETCH_JMP_FOLD_EN folds current-epoch I_JMP beats into a fetch redirect instead of queueing them.
module fetch_queue #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 32,
   parameter int OPC_W   = 6,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2,
   parameter int PC_STEP = 4,
   parameter logic [OPC_W-1:0] I_JMP = OPC_W'(2),
   parameter logic [OPC_W-1:0] I_BEQ = OPC_W'(4),
   parameter logic [OPC_W-1:0] I_BLT = OPC_W'(5)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic              take_flag,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       m_araddr,
   output logic [3:0]        m_arid,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [3:0]        m_rid,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [ADDR_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_inst,
   output logic              o_taken,
   output logic [ADDR_W-1:0] o_target,
   output logic              o_fault
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [ADDR_W-1:0] r_pc;
   logic [2:0]        r_epoch;
   logic [OW-1:0]     r_outst;
   logic              r_ar_hold;
   logic [ADDR_W-1:0] r_ar_pc;
   logic [2:0]        r_ar_ep;
   logic [ADDR_W-1:0] r_sh [MAX_OUT];
   logic [SW-1:0]     r_sh_wp, r_sh_rp;
   logic [ADDR_W-1:0] r_f_pc    [DEPTH];
   logic [DATA_W-1:0] r_f_inst  [DEPTH];
   logic              r_f_taken [DEPTH];
   logic              r_f_fault [DEPTH];
   logic [PW-1:0]     r_wp, r_rp;
   logic [CW-1:0]     r_count;

   logic              w_issue_ok, w_ar_hs, w_cur, w_ok, w_branch, w_pred, w_fold, w_push, w_pop;
   logic [ADDR_W-1:0] w_ar_pc, w_target;
   logic [2:0]        w_ar_ep;
   logic [OPC_W-1:0]  w_opc;

   function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
      return (p == SW'(MAX_OUT - 1)) ? '0 : p + SW'(1);
   endfunction

   // A request that was offered but not accepted is frozen in r_ar_* until the handshake.
   assign w_issue_ok = ce && (int'(r_outst) + int'(r_count) < DEPTH) && (int'(r_outst) < MAX_OUT);
   assign m_arvalid  = nrst && (r_ar_hold || w_issue_ok);
   assign w_ar_pc    = r_ar_hold ? r_ar_pc : r_pc;
   assign w_ar_ep    = r_ar_hold ? r_ar_ep : r_epoch;
   assign m_araddr   = {{(32-ADDR_W){1'b0}}, w_ar_pc};
   assign m_arid     = {1'b0, w_ar_ep};
   assign m_arlen    = 8'd0;
   assign m_arsize   = 3'd2;
   assign m_arburst  = 2'd1;
   assign m_rready   = 1'b1;
   assign w_ar_hs    = m_arvalid && m_arready;

   assign w_cur    = m_rvalid && (m_rid == {1'b0, r_epoch});
   assign w_ok     = (m_rresp == 2'b00);
   assign w_opc    = m_rdata[DATA_W-1 -: OPC_W];
   assign w_target = m_rdata[ADDR_W-1:0];
   assign w_branch = (w_opc == I_BEQ) || (w_opc == I_BLT);
   assign w_pred   = w_cur && w_ok && take_flag && w_branch;
`ifdef FETCH_JMP_FOLD_EN
   assign w_fold   = w_cur && w_ok && (w_opc == I_JMP);
`else
   assign w_fold   = 1'b0;
`endif
   assign w_push   = w_cur && !w_fold && !redirect_valid;
   assign w_pop    = o_valid && o_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_pc      <= '0;
         r_epoch   <= '0;
         r_outst   <= '0;
         r_ar_hold <= 1'b0;
         r_ar_pc   <= '0;
         r_ar_ep   <= '0;
         r_sh_wp   <= '0;
         r_sh_rp   <= '0;
      end else begin
         if (m_arvalid && !m_arready) begin
            r_ar_hold <= 1'b1;
            r_ar_pc   <= w_ar_pc;
            r_ar_ep   <= w_ar_ep;
         end else if (w_ar_hs) begin
            r_ar_hold <= 1'b0;
         end
         // A held request from an older epoch no longer matches r_pc, so it must not advance it.
         if (redirect_valid)
            r_pc <= redirect_pc;
         else if (w_pred || w_fold)
            r_pc <= w_target;
         else if (w_ar_hs && (w_ar_ep == r_epoch))
            r_pc <= r_pc + ADDR_W'(PC_STEP);
         if (redirect_valid || w_pred || w_fold)
            r_epoch <= r_epoch + 3'd1;
         r_outst <= r_outst + OW'(w_ar_hs) - OW'(m_rvalid);
         if (w_ar_hs) r_sh_wp <= sh_next(r_sh_wp);
         if (m_rvalid) r_sh_rp <= sh_next(r_sh_rp);
      end
   end

   always_ff @(posedge clk) begin
      if (nrst && w_ar_hs) r_sh[r_sh_wp] <= w_ar_pc;
      if (nrst && w_push) begin
         r_f_pc[r_wp]    <= r_sh[r_sh_rp];
         r_f_inst[r_wp]  <= m_rdata;
         r_f_taken[r_wp] <= w_pred;
         r_f_fault[r_wp] <= !w_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst || redirect_valid) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop)  r_rp <= r_rp + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign o_valid  = (r_count != '0);
   assign o_pc     = r_f_pc[r_rp];
   assign o_inst   = r_f_inst[r_rp];
   assign o_taken  = r_f_taken[r_rp];
   assign o_fault  = r_f_fault[r_rp];
   assign o_target = r_f_inst[r_rp][ADDR_W-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: AXI read slave with random latency, architectural stream model, scoreboard.
module tb_fetch_queue;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int DEPTH = 4;
   localparam int MAX_OUT = 2;
   localparam int EW = ADDR_W + DATA_W + 2;
   localparam logic [5:0] OP_JMP = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BLT = 6'h05;

   logic clk, nrst, ce, take_flag, redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0] m_araddr;
   logic [3:0] m_arid, m_rid;
   logic [7:0] m_arlen;
   logic [2:0] m_arsize;
   logic [1:0] m_arburst, m_rresp;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
   logic [DATA_W-1:0] m_rdata;
   logic o_valid, o_ready, o_taken, o_fault;
   logic [ADDR_W-1:0] o_pc, o_target;
   logic [DATA_W-1:0] o_inst;

   fetch_queue dut (
      .clk(clk), .nrst(nrst), .ce(ce), .take_flag(take_flag),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
      .m_rready(m_rready), .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc),
      .o_inst(o_inst), .o_taken(o_taken), .o_target(o_target), .o_fault(o_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int pops = 0;
   logic [EW-1:0] exp_q[$];
   logic [ADDR_W-1:0] gen_pc;

   typedef struct packed {logic [31:0] addr; logic [3:0] id;} ar_t;
   ar_t ar_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Code memory contents are a fixed pseudo-random function of the address.
   function automatic logic [31:0] hsh(input logic [ADDR_W-1:0] a);
      logic [31:0] x;
      x = {17'd0, a} * 32'h9E3779B1;
      x = x ^ (x >> 15);
      x = x * 32'h85EBCA6B;
      x = x ^ (x >> 13);
      return x;
   endfunction

   function automatic logic [31:0] mem_inst(input logic [ADDR_W-1:0] a);
      logic [31:0] h;
      logic [5:0] opc;
      h = hsh(a);
      case (h[3:0])
         4'd0, 4'd1: opc = OP_BEQ;
         4'd2:       opc = OP_BLT;
         4'd3:       opc = OP_JMP;
         default:    opc = 6'h00;
      endcase
      return {opc, h[31:21], 6'd0, h[14:8], 2'b00};
   endfunction

   function automatic logic mem_take(input logic [ADDR_W-1:0] a);
      logic [31:0] h;
      h = hsh(a);
      return h[5];
   endfunction

   function automatic logic mem_fault(input logic [ADDR_W-1:0] a);
      logic [31:0] h;
      h = hsh(a);
      return h[20:16] == 5'd0;
   endfunction

   // Architectural instruction stream from gen_pc: taken branches jump, faults and others fall through.
   task automatic fill();
      int folds;
      logic [31:0] inst;
      logic f, br;
      folds = 0;
      while (exp_q.size() < 16 && folds < 64) begin
         inst = mem_inst(gen_pc);
         f = mem_fault(gen_pc);
         br = (inst[31:26] == OP_BEQ || inst[31:26] == OP_BLT) && mem_take(gen_pc) && !f;
`ifdef FETCH_JMP_FOLD_EN
         if (inst[31:26] == OP_JMP && !f) begin
            gen_pc = inst[ADDR_W-1:0];
            folds++;
            continue;
         end
`endif
         exp_q.push_back({gen_pc, inst, br, f});
         gen_pc = br ? inst[ADDR_W-1:0] : gen_pc + 15'd4;
      end
   endtask

   // AXI read slave: in-order single-beat responses with random delay.
   initial begin
      ar_t a;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0; take_flag = 1'b0;
      forever begin
         @(negedge clk);
         if (nrst && m_arvalid && m_arready) ar_q.push_back('{m_araddr, m_arid});
         @(posedge clk); #1;
         if (m_rvalid) a = ar_q.pop_front();
         if (ar_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            a = ar_q[0];
            m_rvalid = 1'b1;
            m_rdata = mem_inst(a.addr[ADDR_W-1:0]);
            m_rid = a.id;
            m_rresp = mem_fault(a.addr[ADDR_W-1:0]) ? 2'b10 : 2'b00;
            take_flag = mem_take(a.addr[ADDR_W-1:0]);
         end else begin
            m_rvalid = 1'b0;
            m_rdata = $urandom;
            take_flag = $urandom_range(0, 1) != 0;
         end
         m_arready = $urandom_range(0, 3) != 0;
      end
   end

   // Monitor: scoreboard pops and AR-channel protocol checks.
   initial begin
      logic [EW-1:0] e;
      logic prev_av, prev_ar, first_ar;
      logic [31:0] prev_addr;
      logic [3:0] prev_id;
      int inflight;
      prev_av = 1'b0; prev_ar = 1'b0; prev_addr = '0; prev_id = '0; first_ar = 1'b1; inflight = 0;
      forever begin
         @(negedge clk);
         if (nrst) begin
            if (o_valid && o_ready && !redirect_valid) begin
               if (exp_q.size() == 0) begin
                  check("pop_with_empty_model", 64'(1), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("o_pc", 64'(o_pc), 64'(e[EW-1 -: ADDR_W]));
                  check("o_inst", 64'(o_inst), 64'(e[DATA_W+1:2]));
                  check("o_taken", 64'(o_taken), 64'(e[1]));
                  check("o_fault", 64'(o_fault), 64'(e[0]));
                  check("o_target", 64'(o_target), 64'(e[ADDR_W+1:2]));
                  pops++;
                  fill();
               end
            end
            if (prev_av && !prev_ar) begin
               check("ar_hold_valid", 64'(m_arvalid), 64'(1));
               check("ar_hold_addr", 64'(m_araddr), 64'(prev_addr));
               check("ar_hold_id", 64'(m_arid), 64'(prev_id));
            end else if (!ce) begin
               check("ar_idle_when_ce_low", 64'(m_arvalid), 64'(0));
            end
            if (m_arvalid) begin
               check("ar_fields", 64'({m_araddr[31:ADDR_W], m_arid[3], m_arlen, m_arsize, m_arburst}),
                     64'({17'd0, 1'b0, 8'd0, 3'd2, 2'd1}));
            end
            if (m_arvalid && m_arready) begin
               if (first_ar) begin
                  check("first_ar_addr", 64'(m_araddr), 64'(0));
                  check("first_ar_id", 64'(m_arid), 64'(0));
                  first_ar = 1'b0;
               end
               inflight++;
            end
            if (m_rvalid) inflight--;
            check("outstanding_le_max", 64'(inflight <= MAX_OUT), 64'(1));
            prev_av = m_arvalid; prev_ar = m_arready; prev_addr = m_araddr; prev_id = m_arid;
         end
      end
   end

   // Stimulus: reset, free run, back-pressure fill, then random ce/o_ready/redirects.
   initial begin
      nrst = 1'b0; ce = 1'b1; o_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      gen_pc = '0;
      fill();
      repeat (3) @(posedge clk);
      #1;
      check("reset_arvalid", 64'(m_arvalid), 64'(0));
      check("reset_o_valid", 64'(o_valid), 64'(0));
      check("reset_m_rready", 64'(m_rready), 64'(1));
      nrst = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         redirect_valid = 1'b0;
         if (cyc == 400) begin
            check("full_o_valid", 64'(o_valid), 64'(1));
            check("full_no_arvalid", 64'(m_arvalid), 64'(0));
         end
         if (cyc < 300) begin
            ce = 1'b1;
            o_ready = $urandom_range(0, 3) != 0;
         end else if (cyc < 400) begin
            ce = 1'b1;
            o_ready = 1'b0;
         end else begin
            ce = $urandom_range(0, 7) != 0;
            o_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 39) == 0) begin
               redirect_valid = 1'b1;
               redirect_pc = ADDR_W'({$urandom_range(0, 255), 2'b00});
               exp_q.delete();
               gen_pc = redirect_pc;
               fill();
            end
         end
      end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      check("progress_pops", 64'(pops >= 300), 64'(1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
